// File: rtl/rx_dfe_sweep_ctrl.sv
// rx_dfe_sweep_ctrl
//   Sweeps every (tx_setting, rx_setting) pair driven into rx_dfe. For each pair
//   it pulses the DFE reset, waits for the channel and DFE history to settle,
//   counts bit errors over a fixed window, and keeps the pair with the fewest
//   errors. Ties keep the earlier pair.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       synchronous reset, active-low
//   start       begin a sweep; only looked at while idle
//   err         bit-error strobe from the comparator, one per cycle
//   tx_setting  setting driven to rx_dfe / channel (outer loop)
//   rx_setting  setting driven to rx_dfe (inner loop)
//   dfe_rst     active-high reset to rx_dfe, one cycle per point
//   busy        high from APPLY through DONE inclusive
//   done        one-cycle pulse at the end of the sweep
//   best_tx     tx_setting of the best point
//   best_rx     rx_setting of the best point
//   best_err    error count of the best point (all-ones = none yet)
//
// Configuration
//   RX_DFE_SWEEP_EARLY_EXIT_EN  when defined, a point whose running error count
//   has already reached best_err abandons its window and goes straight to NEXT
//   without a COMPARE cycle. Undefined, every point uses the full window.

module rx_dfe_sweep_ctrl #(
  parameter int TX_W       = 2,
  parameter int RX_W       = 2,
  parameter int SETTLE_CYC = 16,
  parameter int WIN_LOG2   = 10,
  parameter int ERR_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             err,
  output logic [TX_W-1:0]  tx_setting,
  output logic [RX_W-1:0]  rx_setting,
  output logic             dfe_rst,
  output logic             busy,
  output logic             done,
  output logic [TX_W-1:0]  best_tx,
  output logic [RX_W-1:0]  best_rx,
  output logic [ERR_W-1:0] best_err
);

  localparam int PT_W  = TX_W + RX_W;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (WIN_LOG2 > SET_W) ? WIN_LOG2 : SET_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << WIN_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [PT_W-1:0]  point;
  logic [PT_W-1:0]  best_pt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             early_exit;

  // The sweep point is one {tx,rx} counter so rx naturally forms the inner loop.
  assign tx_setting = point[PT_W-1:RX_W];
  assign rx_setting = point[RX_W-1:0];
  assign best_tx    = best_pt[PT_W-1:RX_W];
  assign best_rx    = best_pt[RX_W-1:0];

  // Once the running count equals the best so far this point can no longer win
  // (ties keep the earlier point), so the rest of its window is wasted time.
`ifdef RX_DFE_SWEEP_EARLY_EXIT_EN
  assign early_exit = (err_cnt >= best_err);
`else
  assign early_exit = 1'b0;
`endif

  // Single sequencer: every output is a register updated on the transition
  // into the state that owns it, so outputs are glitch-free toward rx_dfe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      point    <= '0;
      best_pt  <= '0;
      best_err <= '1;
      cyc_cnt  <= '0;
      err_cnt  <= '0;
      dfe_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dfe_rst <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            state    <= S_APPLY;
            point    <= '0;
            best_pt  <= '0;
            best_err <= '1;
            dfe_rst  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_APPLY: begin
          state   <= S_SETTLE;
          dfe_rst <= 1'b0;
          cyc_cnt <= '0;
        end
        // Errors during settling reflect stale DFE history, so the counter is
        // held clear rather than accumulating.
        S_SETTLE: begin
          err_cnt <= '0;
          if (cyc_cnt == SETTLE_LAST) begin
            state   <= S_MEASURE;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (early_exit) begin
            state <= S_NEXT;
          end else begin
            if (err && !(&err_cnt))
              err_cnt <= err_cnt + 1'b1;
            if (cyc_cnt == WIN_LAST)
              state <= S_COMPARE;
            else
              cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          state <= S_NEXT;
          if (err_cnt < best_err) begin
            best_err <= err_cnt;
            best_pt  <= point;
          end
        end
        S_NEXT: begin
          if (&point) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state   <= S_APPLY;
            point   <= point + 1'b1;
            dfe_rst <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          dfe_rst <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_dfe_sweep_ctrl.sv
// tb_rx_dfe_sweep_ctrl
//   Drives rx_dfe_sweep_ctrl with directed and randomized error patterns and
//   compares every output, every cycle, against a timeline model of the sweep.

module tb_rx_dfe_sweep_ctrl;

  localparam int TX_W       = 1;
  localparam int RX_W       = 1;
  localparam int SETTLE_CYC = 4;
  localparam int WIN_LOG2   = 3;
  localparam int ERR_W      = 3;

  localparam int NPTS      = 1 << (TX_W + RX_W);
  localparam int WIN       = 1 << WIN_LOG2;
  localparam int PER_PT    = SETTLE_CYC + WIN + 3;
  localparam int SWEEP_LEN = NPTS * PER_PT;
  localparam int MAXE      = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             err;
  logic [TX_W-1:0]  tx_setting;
  logic [RX_W-1:0]  rx_setting;
  logic             dfe_rst;
  logic             busy;
  logic             done;
  logic [TX_W-1:0]  best_tx;
  logic [RX_W-1:0]  best_rx;
  logic [ERR_W-1:0] best_err;

  rx_dfe_sweep_ctrl #(
    .TX_W(TX_W), .RX_W(RX_W), .SETTLE_CYC(SETTLE_CYC),
    .WIN_LOG2(WIN_LOG2), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .err(err),
    .tx_setting(tx_setting), .rx_setting(rx_setting), .dfe_rst(dfe_rst),
    .busy(busy), .done(done), .best_tx(best_tx), .best_rx(best_rx),
    .best_err(best_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_t is the cycle number since the start cycle (APPLY of point 0 is 1).
  bit m_valid = 0;
  bit m_run   = 0;
  int m_t     = 0;
  int m_cnt   = 0;
  int m_pt    = 0;
  int m_best_pt  = 0;
  int m_best_err = MAXE;
  bit e_dfe, e_busy, e_done;

  // Stimulus controls.
  int plan[NPTS];
  int rate[NPTS];
  int mode    = 0;
  int out_err = 0;
  int cyc     = 0;
  int done_pulses = 0;
  int done_at     = 0;
  int dfe_hi      = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0d expected %0d", name, m_t, act, exp);
    end
  endtask

  function automatic void modelEdge(input logic r, input logic s, input logic e);
    int o;
    if (!r) begin
      m_run = 0; m_pt = 0; m_best_pt = 0; m_best_err = MAXE;
      e_dfe = 1; e_busy = 0; e_done = 0; m_valid = 1;
      return;
    end
    if (!m_run) begin
      e_dfe = 0; e_busy = 0; e_done = 0;
      if (s) begin
        m_run = 1; m_t = 1; m_pt = 0; m_best_pt = 0; m_best_err = MAXE; m_cnt = 0;
        e_dfe = 1; e_busy = 1;
      end
      return;
    end
    if (m_t > SWEEP_LEN) begin
      m_run = 0; e_dfe = 0; e_busy = 0; e_done = 0;
      return;
    end
    o = (m_t - 1) % PER_PT;
    if (o == 0) m_cnt = 0;
    if (o >= SETTLE_CYC + 1 && o <= SETTLE_CYC + WIN && e && m_cnt < MAXE) m_cnt++;
    if (o == SETTLE_CYC + WIN + 1 && m_cnt < m_best_err) begin
      m_best_err = m_cnt;
      m_best_pt  = (m_t - 1) / PER_PT;
    end
    m_t++;
    if (m_t <= SWEEP_LEN) m_pt = (m_t - 1) / PER_PT;
    e_dfe  = (m_t <= SWEEP_LEN) && ((m_t - 1) % PER_PT == 0);
    e_busy = 1;
    e_done = (m_t == SWEEP_LEN + 1);
  endfunction

  task automatic compareAll();
    if (!m_valid) return;
    checkOutput("tx_setting", 32'(tx_setting), m_pt >> RX_W);
    checkOutput("rx_setting", 32'(rx_setting), m_pt & ((1 << RX_W) - 1));
    checkOutput("dfe_rst", 32'(dfe_rst), 32'(e_dfe));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("best_tx", 32'(best_tx), m_best_pt >> RX_W);
    checkOutput("best_rx", 32'(best_rx), m_best_pt & ((1 << RX_W) - 1));
    checkOutput("best_err", 32'(best_err), m_best_err);
    if (done === 1'b1) begin
      done_pulses++;
      done_at = cyc;
    end
    if (dfe_rst === 1'b1) dfe_hi++;
  endtask

  // One clock: choose err from the bench's own timeline, drive, advance model, compare.
  task automatic applyStimulus(input logic rst_v, input logic start_v);
    logic e;
    bit   start_edge;
    int   o, k, mi;
    e = ($urandom_range(0, 1) == 1);
    if (m_run && m_t <= SWEEP_LEN) begin
      o = (m_t - 1) % PER_PT;
      k = (m_t - 1) / PER_PT;
      if (o >= SETTLE_CYC + 1 && o <= SETTLE_CYC + WIN) begin
        mi = o - SETTLE_CYC - 1;
        if (mode == 0) e = (mi < plan[k]);
        else           e = ($urandom_range(0, 99) < rate[k]);
      end else if (out_err != 2) begin
        e = (out_err == 1);
      end
    end
    rst_n = rst_v;
    start = start_v;
    err   = e;
    start_edge = !m_run && start_v && rst_v;
    @(posedge clk);
    modelEdge(rst_v, start_v, e);
    if (start_edge) cyc = 1;
    else            cyc++;
    @(negedge clk);
    compareAll();
  endtask

  task automatic runSweep(input int pulse_at, input int rst_at, input bit hold);
    int budget;
    done_pulses = 0; done_at = 0; dfe_hi = 0;
    applyStimulus(1'b1, 1'b1);
    budget = 0;
    while (m_run && budget < SWEEP_LEN + 10) begin
      applyStimulus((cyc == rst_at) ? 1'b0 : 1'b1, hold || (cyc == pulse_at));
      budget++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; err = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_dfe_rst", 32'(dfe_rst), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_best_err", 32'(best_err), 7);
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_dfe_rst", 32'(dfe_rst), 0);

    // Window counts 5,2,2,7 with noise outside the window.
    mode = 0; out_err = 2; plan = '{5, 2, 2, 7};
    runSweep(-1, -1, 1'b0);
    checkOutput("t1_best_tx", 32'(best_tx), 0);
    checkOutput("t1_best_rx", 32'(best_rx), 1);
    checkOutput("t1_best_err", 32'(best_err), 2);
    checkOutput("t1_done_at", done_at, 61);
    checkOutput("t1_done_pulses", done_pulses, 1);
    repeat (2) applyStimulus(1'b1, 1'b0);

    // Every point saturates.
    plan = '{WIN, WIN, WIN, WIN};
    runSweep(-1, -1, 1'b0);
    checkOutput("t2_best_err", 32'(best_err), 7);
    checkOutput("t2_best_tx", 32'(best_tx), 0);
    checkOutput("t2_best_rx", 32'(best_rx), 0);
    applyStimulus(1'b1, 1'b0);

    // Start pulse during MEASURE of point 1 is ignored.
    mode = 1;
    foreach (rate[i]) rate[i] = $urandom_range(0, 99);
    runSweep(1 + PER_PT + SETTLE_CYC + 3, -1, 1'b0);
    checkOutput("t3_done_pulses", done_pulses, 1);
    applyStimulus(1'b1, 1'b0);

    // Reset mid-MEASURE of point 2.
    runSweep(-1, 1 + 2 * PER_PT + SETTLE_CYC + 3, 1'b0);
    checkOutput("t4_dfe_rst", 32'(dfe_rst), 1);
    checkOutput("t4_busy", 32'(busy), 0);
    checkOutput("t4_best_err", 32'(best_err), 7);
    checkOutput("t4_tx", 32'(tx_setting), 0);
    checkOutput("t4_done_pulses", done_pulses, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_dfe_rst_after", 32'(dfe_rst), 0);

    // err only outside the window.
    mode = 0; out_err = 1; plan = '{0, 0, 0, 0};
    runSweep(-1, -1, 1'b0);
    checkOutput("t5_best_err", 32'(best_err), 0);
    checkOutput("t5_dfe_pulses", dfe_hi, NPTS);
    applyStimulus(1'b1, 1'b0);

    // Randomized sweeps; one keeps start high straight into the next sweep.
    mode = 1; out_err = 2;
    for (int rep = 0; rep < 8; rep++) begin
      foreach (rate[i]) begin
        case ($urandom_range(0, 3))
          0: rate[i] = 0;
          1: rate[i] = 20;
          2: rate[i] = 50;
          default: rate[i] = 90;
        endcase
      end
      runSweep(-1, -1, rep == 3);
      checkOutput("rand_done_pulses", done_pulses, 1);
      if (rep != 3) applyStimulus(1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
